// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: anti-ghost blanking, per-digit dp, PWM brightness.
// Define SEG_SCAN_BLINK_EN to build the per-digit blink logic (frame counter + blink phase).
module seg_scan_ctrl #(
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 16,
   parameter int BLINK_FRAMES = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   digits,
   input  logic [DIGITS-1:0]     en,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blink,
   input  logic [3:0]            bright,
   output logic [DIGITS-1:0]     seg_en,
   output logic [7:0]            seg_out,
   output logic                  frame_tick
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

   function automatic logic [7:0] hex_glyph(input logic [3:0] v);
      logic [7:0] g;
      unique case (v)
         4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
         4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
         4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
         4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
      endcase
      return g;
   endfunction

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
   logic [3:0]        pwm_q, pwm_d;
   logic [3:0]        lat_nib_q, lat_nib_d, lat_bright_q, lat_bright_d;
   logic              lat_en_q, lat_en_d, lat_dp_q, lat_dp_d;
   logic [DIGITS-1:0] seg_en_q, seg_en_d;
   logic [7:0]        seg_out_q, seg_out_d;
   logic              frame_tick_q, frame_tick_d;
   logic              slot_tick, frame_wrap, suppress, lit;
   logic [3:0]        nxt_nib;
   logic              nxt_en, nxt_dp;
   logic [DIGITS-1:0] sel;
   logic [7:0]        glyph;

`ifdef SEG_SCAN_BLINK_EN
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
   logic [FC_W-1:0] fcnt_q, fcnt_d;
   logic            blink_phase_q, blink_phase_d;
   logic            lat_blink_q, lat_blink_d, nxt_blink;
`else
   logic            unused_blink;
   assign unused_blink = ^blink;
`endif

   assign slot_tick  = (pre_q == PRE_LAST);
   assign frame_wrap = slot_tick && (idx_q == IDX_LAST);
   assign idx_nxt    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

   // Fetch the upcoming position's inputs so they can be frozen at the slot tick.
   always_comb begin
      nxt_nib = '0;
      nxt_en  = 1'b0;
      nxt_dp  = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      nxt_blink = 1'b0;
`endif
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_nxt == IDX_W'(k)) begin
            nxt_nib = digits[4*k +: 4];
            nxt_en  = en[k];
            nxt_dp  = dp[k];
`ifdef SEG_SCAN_BLINK_EN
            nxt_blink = blink[k];
`endif
         end
      end
   end

   always_comb begin
      pre_d        = slot_tick ? '0 : pre_q + 1'b1;
      pwm_d        = pwm_q + 1'b1;
      idx_d        = idx_q;
      lat_nib_d    = lat_nib_q;
      lat_en_d     = lat_en_q;
      lat_dp_d     = lat_dp_q;
      lat_bright_d = lat_bright_q;
      frame_tick_d = frame_wrap;
      if (slot_tick) begin
         idx_d        = idx_nxt;
         lat_nib_d    = nxt_nib;
         lat_en_d     = nxt_en;
         lat_dp_d     = nxt_dp;
         lat_bright_d = bright;
      end
`ifdef SEG_SCAN_BLINK_EN
      fcnt_d        = fcnt_q;
      blink_phase_d = blink_phase_q;
      lat_blink_d   = slot_tick ? nxt_blink : lat_blink_q;
      if (frame_wrap) begin
         if (fcnt_q == FC_LAST) begin
            fcnt_d        = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
      suppress = blink_phase_q & lat_blink_q;
`else
      suppress = 1'b0;
`endif
      for (int k = 0; k < DIGITS; k++) sel[k] = (idx_q == IDX_W'(k));
      lit       = (pre_q >= PRE_BLANK) && lat_en_q && (pwm_q <= lat_bright_q) && !suppress;
      glyph     = hex_glyph(lat_nib_q);
      // Segments follow the select: the bus stays released whenever no digit is on.
      seg_en_d  = lit ? ~sel : '1;
      seg_out_d = lit ? {glyph[7] & ~lat_dp_q, glyph[6:0]} : 8'hFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q        <= '0;
         idx_q        <= '0;
         pwm_q        <= '0;
         lat_nib_q    <= '0;
         lat_en_q     <= 1'b0;
         lat_dp_q     <= 1'b0;
         lat_bright_q <= '0;
         seg_en_q     <= '1;
         seg_out_q    <= 8'hFF;
         frame_tick_q <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
         fcnt_q        <= '0;
         blink_phase_q <= 1'b0;
         lat_blink_q   <= 1'b0;
`endif
      end else begin
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         pwm_q        <= pwm_d;
         lat_nib_q    <= lat_nib_d;
         lat_en_q     <= lat_en_d;
         lat_dp_q     <= lat_dp_d;
         lat_bright_q <= lat_bright_d;
         seg_en_q     <= seg_en_d;
         seg_out_q    <= seg_out_d;
         frame_tick_q <= frame_tick_d;
`ifdef SEG_SCAN_BLINK_EN
         fcnt_q        <= fcnt_d;
         blink_phase_q <= blink_phase_d;
         lat_blink_q   <= lat_blink_d;
`endif
      end
   end

   assign seg_en     = seg_en_q;
   assign seg_out    = seg_out_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-count based model predicts every output cycle.
module tb_seg_scan_ctrl;
   localparam int DIGITS       = 4;
   localparam int SCAN_DIV     = 8;
   localparam int BLANK_CYC    = 2;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME        = DIGITS * SCAN_DIV;
`ifdef SEG_SCAN_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   typedef struct packed {
      logic [DIGITS-1:0] sen;
      logic [7:0]        sout;
      logic              ft;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4*DIGITS-1:0] digits = '0;
   logic [DIGITS-1:0]   en = '0, dp = '0, blink = '0;
   logic [3:0]          bright = '0;
   logic [DIGITS-1:0]   seg_en;
   logic [7:0]          seg_out;
   logic                frame_tick;

   int total = 0;
   int bad   = 0;
   exp_t sb_q[$];

   logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Model view: n = cycles since reset release; slot data captured at each slot's last cycle.
   int         n = 0;
   logic [3:0] m_nib = '0, m_bright = '0;
   logic       m_en = 1'b0, m_dp = 1'b0, m_blink = 1'b0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .digits(digits), .en(en), .dp(dp), .blink(blink),
      .bright(bright), .seg_en(seg_en), .seg_out(seg_out), .frame_tick(frame_tick)
   );

   task automatic model_step();
      exp_t e;
      int pos, off, pwm, ph, np;
      logic lit;
      logic [DIGITS-1:0] oh;
      if (rst) begin
         n = 0; m_nib = '0; m_bright = '0; m_en = 1'b0; m_dp = 1'b0; m_blink = 1'b0;
         e.sen = '1; e.sout = 8'hFF; e.ft = 1'b0;
      end else begin
         pos = (n / SCAN_DIV) % DIGITS;
         off = n % SCAN_DIV;
         pwm = n % 16;
         ph  = (n / FRAME / BLINK_FRAMES) % 2;
         lit = (off >= BLANK_CYC) && m_en && (pwm <= int'(m_bright));
         if (BLINK_ON && ph == 1 && m_blink) lit = 1'b0;
         oh     = DIGITS'(1) << pos;
         e.sen  = lit ? ~oh : '1;
         e.sout = lit ? (glyph_tab[m_nib] & (m_dp ? 8'h7F : 8'hFF)) : 8'hFF;
         e.ft   = ((n % FRAME) == FRAME - 1);
         if (off == SCAN_DIV - 1) begin
            np       = ((n / SCAN_DIV) + 1) % DIGITS;
            m_nib    = digits[4*np +: 4];
            m_en     = en[np];
            m_dp     = dp[np];
            m_blink  = blink[np];
            m_bright = bright;
         end
         n++;
      end
      sb_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         total++;
         if (seg_en !== e.sen || seg_out !== e.sout || frame_tick !== e.ft) begin
            bad++;
            $display("FAIL scan_out t=%0t seg_en got %b want %b, seg_out got %h want %h, frame_tick got %b want %b",
                     $time, seg_en, e.sen, seg_out, e.sout, frame_tick, e.ft);
         end
      end
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic do_reset(input int k);
      rst = 1'b1;
      cyc(k);
      rst = 1'b0;
   endtask

   // Wait (bounded) until the state currently in the DUT is at a given frame offset.
   task automatic wait_offset(input int target);
      int guard;
      guard = 0;
      while ((n % FRAME) != target && guard < 4 * FRAME) begin
         cyc(1);
         guard++;
      end
      total++;
      if (guard >= 4 * FRAME) begin
         bad++;
         $display("FAIL wait_offset got timeout want offset %0d", target);
      end
   endtask

   initial begin
      int ft_at;
      digits = 16'h3210; en = 4'hF; dp = 4'h0; blink = 4'h0; bright = 4'd15;
      cyc(3);
      total++;
      if (seg_en !== 4'hF || seg_out !== 8'hFF || frame_tick !== 1'b0) begin
         bad++;
         $display("FAIL reset_outs got %b/%h/%b want 1111/ff/0", seg_en, seg_out, frame_tick);
      end
      rst = 1'b0;
      ft_at = -1;
      for (int i = 1; i <= 100; i++) begin
         cyc(1);
         if (frame_tick === 1'b1) begin
            ft_at = i;
            break;
         end
      end
      total++;
      if (ft_at != 32) begin
         bad++;
         $display("FAIL first_frame_tick got %0d want 32", ft_at);
      end
      cyc(3 * FRAME + 3);
      do_reset(3);
      cyc(2 * FRAME);
      en = 4'b1011; dp = 4'b0001;
      cyc(3 * FRAME);
      en = 4'hF; dp = 4'h0; bright = 4'd3;
      cyc(16 * FRAME);
      bright = 4'd15; blink = 4'b0010;
      cyc(10 * FRAME);
      blink = 4'h0;
      wait_offset(2 * SCAN_DIV + 4);
      digits[11:8] = 4'hE;
      cyc(2 * FRAME);
      for (int it = 0; it < 60; it++) begin
         digits = 16'($urandom);
         en     = 4'($urandom);
         dp     = 4'($urandom);
         blink  = 4'($urandom);
         bright = 4'($urandom);
         if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
         cyc($urandom_range(1, 40));
      end
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment scan controller, next generation of the fixed 8-digit display driver. It time-multiplexes `DIGITS` hex digits onto one shared active-low segment bus. It adds anti-ghost blanking, per-digit decimal points, global PWM brightness and per-digit blinking. It sits between the clock/alarm datapath (BCD/hex digit registers) and the board's digit-select and segment pins.

## Interface
- `DIGITS`, 8: number of digit positions, 2..16.
- `SCAN_DIV`, 50000: clock cycles per digit slot, ≥ 4.
- `BLANK_CYC`, 16: cycles at the start of each slot with all digits off, < `SCAN_DIV`.
- `BLINK_FRAMES`, 50: full scan frames per blink half-period, ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `digits`  in  4*DIGITS  hex value per position; position k = `digits[4k+3:4k]`.
- `en`  in  DIGITS  per-position enable; 0 = position stays dark, but its slot is still consumed.
- `dp`  in  DIGITS  per-position decimal point request, 1 = lit.
- `blink`  in  DIGITS  per-position blink request.
- `bright`  in  4  global brightness; on-time = (bright+1)/16.
- `seg_en`  out  DIGITS  digit selects, active-low, one-cold or all ones.
- `seg_out`  out  8  segments `{dp,g,f,e,d,c,b,a}`, active-low.
- `frame_tick`  out  1  one-cycle pulse at the start of slot 0 of every frame.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1 and wraps. The cycle where `pre`==SCAN_DIV-1 is the slot tick.
- Position index `idx` advances on each slot tick: 0..DIGITS-1, then wraps to 0. A wrap completes one frame.
- At each slot tick, the controller latches the following for the next position (`idx`+1 mod DIGITS):
  - its nibble, `en`, `dp` and `blink` bits,
  - the current `bright`.
- Inputs changing mid-slot have no effect until that position's next slot.
- Decoder, glyphs for 0..F, active-low:
  - 0=8'hC0, 1=8'hF9, 2=8'hA4, 3=8'hB0, 4=8'h99, 5=8'h92, 6=8'h82, 7=8'hF8
  - 8=8'h80, 9=8'h90, A=8'h88, b=8'h83, C=8'hC6, d=8'hA1, E=8'h86, F=8'h8E
  - The `dp` bit clears bit 7.
- PWM counter `pwm` is 4 bits, free-running, increments every cycle, resets to 0.
- Position k is driven (`seg_en[k]`=0) only when all of these hold:
  - `idx`==k,
  - `pre` ≥ BLANK_CYC,
  - latched `en`=1,
  - `pwm` ≤ latched `bright`,
  - not blink-suppressed.
- Otherwise `seg_en` is all ones and `seg_out`=8'hFF. The segment bus is never driven while all digits are off.
- Blink: the frame counter counts 0..BLINK_FRAMES-1. At wrap, `blink_phase` toggles. While `blink_phase`=1, positions with latched `blink`=1 are suppressed.
- `frame_tick` pulses in the cycle after the slot tick that wraps `idx` to 0.

## Timing
- Reset values, applied one cycle after `rst` is sampled high:
  - `seg_en`=all ones, `seg_out`=8'hFF, `frame_tick`=0
  - `pre`=0, `idx`=0, `pwm`=0, frame counter=0, `blink_phase`=0
  - latched slot data = position 0 with `en`=0
- Reset mid-slot aborts the slot immediately. The first slot after reset is position 0, which is dark for the whole slot because latched `en`=0.
- The first real data appears at position 1, SCAN_DIV cycles after reset release. Position 0 shows real data from the next frame onward.
- All outputs are registered. `seg_en`/`seg_out` reflect the state of the previous cycle, giving a fixed 1-cycle latency from internal counters to pins.
- Blanking: for the first BLANK_CYC cycles of every slot, including slot 0 after a wrap, `seg_en` is all ones.
- `bright`=15: no PWM gaps. `bright`=0: lit 1 cycle in 16.
- Blink half-period = BLINK_FRAMES × DIGITS × SCAN_DIV cycles.

## Configuration
- `SEG_SCAN_BLINK_EN` defined: blink counter, `blink_phase` and suppression are implemented as above.
- Undefined: the `blink` port remains but is ignored, the frame/blink counters are not built, and no position is ever blink-suppressed. `frame_tick` is still produced.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
- Reset: assert `rst` 3 cycles mid-slot, release → `seg_en`=4'b1111 and `seg_out`=8'hFF until the position-1 slot. `frame_tick` first pulses 32 cycles after release.
- Scan order: `digits`=16'h3210, `en`=4'hF, `bright`=15, `dp`=0 → per slot, 2 dark cycles then 6 lit cycles. `seg_en` sequence is 1110/1101/1011/0111 with `seg_out` C0/F9/A4/B0, then repeats.
- Enable/dp: `en`=4'b1011, `dp`=4'b0001 → position 0 shows 8'h40 (`digits` nibble 0 = 0). Position 2 slot stays all ones for 8 cycles, and the scan period is still 32.
- Brightness: `bright`=3 → within lit window, `seg_en` active only when `pwm`∈0..3. Count active cycles over 16 consecutive frames = 25% ±1 of non-blanked cycles.
- Blink (macro on): `blink`=4'b0010 → position 1 dark during frames 2–3, 6–7…, and all others unaffected. Macro off → position 1 never suppressed.
- Mid-slot change: change `digits` nibble 2 during position 2's lit window → output unchanged until the next position-2 slot.
